mult_issue_ctrl: RTL and testbench
==================================

# mult_issue_ctrl

Sequencing front end for the 32-bit radix-4 Booth multiplier in the multdiv path. Accepts a one-cycle multiply request with two operands and holds them stable for the multiplier. Clears the multiplier, waits for its `ready`, then registers product and overflow toward the writeback side with a one-cycle `data_resultRDY` strobe. Adds a zero-operand fast path, restart on a new request, and a watchdog that aborts a multiplier that never reports ready.

## Interface
- `TIMEOUT`, default 20: cycles in RUN before abort; legal range 17..31.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; `reset`=0 at a rising edge forces reset state.
- `ctl_MULT`  in  1  request strobe; sampled every edge.
- `data_operandA`  in  32  multiplicand; sampled with `ctl_MULT`.
- `data_operandB`  in  32  multiplier; sampled with `ctl_MULT`.
- `mult_multiplicand`  out  32  latched A, driven to the multiplier.
- `mult_multiplier`  out  32  latched B, driven to the multiplier.
- `mult_reset`  out  1  active-high clear to the multiplier; high for exactly the CLEAR cycle.
- `mult_result`  in  32  multiplier product, low 32 bits.
- `mult_overflow`  in  1  multiplier overflow flag.
- `mult_ready`  in  1  multiplier done flag.
- `data_result`  out  32  registered product.
- `data_exception`  out  1  registered error flag: overflow or timeout.
- `data_resultRDY`  out  1  one-cycle strobe; result and exception valid.
- `busy`  out  1  high in CLEAR and RUN.

## Operation
- States: IDLE, CLEAR, RUN, DONE. Encoded in 2 bits.
- IDLE:
  - `ctl_MULT`=1 with either operand zero: latch operands, load `data_result`=0 and `data_exception`=0, then go to DONE. The multiplier is not cleared.
  - `ctl_MULT`=1 with both operands nonzero: latch operands, then go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR:
  - `mult_reset`=1 for this single cycle.
  - Watchdog counter (5 bits) cleared to 0.
  - Always go to RUN.
- RUN:
  - Watchdog increments each cycle, saturating at 31.
  - `mult_ready`=1: capture `data_result`=`mult_result` and `data_exception`=`mult_overflow`, then go to DONE.
  - Else, if the watchdog equals TIMEOUT−1: capture `data_result`=0 and `data_exception`=1, then go to DONE.
- DONE:
  - `data_resultRDY`=1 for this single cycle.
  - `ctl_MULT`=1 here is handled exactly as in IDLE (back-to-back).
  - Otherwise go to IDLE.
- Request during CLEAR or RUN: abort the current operation and relatch the operands. The zero test applies as in IDLE: go to CLEAR, or to DONE on a zero operand. No `data_resultRDY` is produced for the aborted operation.
- `mult_ready` is ignored outside RUN. The CLEAR cycle guarantees that a stale `ready` from the previous operation is never captured.
- `data_result` and `data_exception` hold their values until the next capture.
- `mult_multiplicand` and `mult_multiplier` change only on an accepted request.

## Timing
- Reset values (`reset`=0 at an edge):
  - state IDLE;
  - all registered outputs 0: `data_result`, `data_exception`, `data_resultRDY`, `busy`, `mult_multiplicand`, `mult_multiplier`, watchdog;
  - `mult_reset`=1 in the cycle following reset, so the multiplier is also cleared.
- `reset`=0 mid-operation wins over any simultaneous `ctl_MULT` or `mult_ready`. No strobe is issued.
- Request accepted at edge 0, nonzero operands:
  - cycle 1 is CLEAR;
  - RUN starts at cycle 2;
  - if the multiplier asserts ready K cycles into RUN (K≥1; K=16 for the Booth unit), the capture is at edge K+1 and `data_resultRDY` is high in cycle K+2.
- Zero fast path: request at edge 0 gives `data_resultRDY` high in cycle 1.
- Timeout: with no ready, `data_resultRDY` is high in cycle TIMEOUT+2.
- `mult_ready` and the timeout condition in the same RUN cycle: ready wins and the real result is captured.
- Outputs are registered. `mult_reset` and `busy` are decoded from state; `busy` is glitch-free by construction.

## Test plan
- Basic multiply: A=7, B=−3 (0xFFFFFFFD), behavioural multiplier stub with K=16.
  - Response: `data_resultRDY` high exactly in cycle 18.
  - `data_result`=0xFFFFFFEB, `data_exception`=0.
  - `busy` high in cycles 1..17.
- Overflow: A=0x00010000, B=0x00010000, stub raises overflow.
  - Response: `data_result`=0x00000000, `data_exception`=1, single strobe.
- Zero fast path: A=0, B=0x12345678.
  - Response: strobe in cycle 1, `data_result`=0, `mult_reset` never asserted.
- Restart: request A=5, B=6, then a second request A=3, B=4 at edge 8.
  - Response: `mult_reset` again in cycle 9.
  - Exactly one strobe, with `data_result`=12, in cycle 26.
- Timeout: stub with `mult_ready` tied 0, TIMEOUT=20.
  - Response: strobe in cycle 22 with `data_exception`=1 and `data_result`=0.
- Reset mid-RUN: `reset`=0 at edge 10 of an operation.
  - Response: all outputs 0 after that edge, no strobe.
  - `mult_reset`=1 in cycle 11, state IDLE after `reset` returns to 1.

Source files
------------

// File: rtl/mult_issue_ctrl.sv
// Issue/sequencing front end for the radix-4 Booth multiplier: latches operands, clears the
// unit, waits for ready (or a watchdog abort) and registers the result with a one-cycle strobe.
module mult_issue_ctrl #(
   parameter int unsigned TIMEOUT = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctl_MULT,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] mult_multiplicand,
   output logic [31:0] mult_multiplier,
   output logic        mult_reset,
   input  logic [31:0] mult_result,
   input  logic        mult_overflow,
   input  logic        mult_ready,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   // Encoding puts CLEAR and RUN on state[1] so busy is a single flop output.
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_DONE  = 2'b01,
      S_CLEAR = 2'b10,
      S_RUN   = 2'b11
   } state_t;

   localparam logic [4:0] WD_LIMIT = 5'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [4:0]  wd, wd_nxt;
   logic        post_rst;
   logic        zero_op;
   logic        capture;
   logic [31:0] res_nxt;
   logic        exc_nxt;

   assign zero_op = (data_operandA == 32'd0) || (data_operandB == 32'd0);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_nxt = state;
      wd_nxt    = wd;
      capture   = 1'b0;
      res_nxt   = data_result;
      exc_nxt   = data_exception;

      unique case (state)
         S_CLEAR: wd_nxt = 5'd0;
         S_RUN:   if (wd != 5'd31) wd_nxt = wd + 5'd1;
         default: ;
      endcase

      if (ctl_MULT) begin
         // A request in any state restarts; the aborted operation never strobes.
         if (zero_op) begin
            state_nxt = S_DONE;
            capture   = 1'b1;
            res_nxt   = 32'd0;
            exc_nxt   = 1'b0;
         end else begin
            state_nxt = S_CLEAR;
         end
      end else begin
         unique case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_CLEAR: state_nxt = S_RUN;
            S_RUN: begin
               if (mult_ready) begin
                  state_nxt = S_DONE;
                  capture   = 1'b1;
                  res_nxt   = mult_result;
                  exc_nxt   = mult_overflow;
               end else if (wd == WD_LIMIT) begin
                  state_nxt = S_DONE;
                  capture   = 1'b1;
                  res_nxt   = 32'd0;
                  exc_nxt   = 1'b1;
               end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         state             <= S_IDLE;
         wd                <= 5'd0;
         post_rst          <= 1'b1;
         mult_multiplicand <= 32'd0;
         mult_multiplier   <= 32'd0;
         data_result       <= 32'd0;
         data_exception    <= 1'b0;
         data_resultRDY    <= 1'b0;
      end else begin
         state          <= state_nxt;
         wd             <= wd_nxt;
         post_rst       <= 1'b0;
         data_resultRDY <= (state_nxt == S_DONE);
         if (ctl_MULT) begin
            mult_multiplicand <= data_operandA;
            mult_multiplier   <= data_operandB;
         end
         if (capture) begin
            data_result    <= res_nxt;
            data_exception <= exc_nxt;
         end
      end
   end

   // The cycle after reset also clears the multiplier.
   assign mult_reset = (state == S_CLEAR) || post_rst;
   assign busy       = state[1];

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl: behavioural multiplier stub plus a scoreboard
// of expected strobes (edge, result, exception) pushed when each request is driven.
module tb_mult_issue_ctrl;

   localparam int TIMEOUT = 20;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ctl_MULT = 1'b0;
   logic [31:0] data_operandA = 32'd0;
   logic [31:0] data_operandB = 32'd0;
   logic [31:0] mult_multiplicand, mult_multiplier;
   logic        mult_reset;
   logic [31:0] mult_result;
   logic        mult_overflow, mult_ready;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY, busy;

   mult_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clock             (clock),
      .reset             (reset),
      .ctl_MULT          (ctl_MULT),
      .data_operandA     (data_operandA),
      .data_operandB     (data_operandB),
      .mult_multiplicand (mult_multiplicand),
      .mult_multiplier   (mult_multiplier),
      .mult_reset        (mult_reset),
      .mult_result       (mult_result),
      .mult_overflow     (mult_overflow),
      .mult_ready        (mult_ready),
      .data_result       (data_result),
      .data_exception    (data_exception),
      .data_resultRDY    (data_resultRDY),
      .busy              (busy)
   );

   always #5 clock = ~clock;

   int edge_cnt = 0;
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   // Multiplier stub: ready K cycles into RUN, counted from the clear pulse.
   int         stub_k = 16;
   bit         stub_never = 1'b0;
   logic [4:0] stub_cnt = 5'd0;
   longint     prod;

   always @(posedge clock) begin
      if (mult_reset) stub_cnt <= 5'd0;
      else if (stub_cnt != 5'd31) stub_cnt <= stub_cnt + 5'd1;
   end

   always_comb prod = longint'($signed(mult_multiplicand)) * longint'($signed(mult_multiplier));
   assign mult_result   = prod[31:0];
   assign mult_overflow = (prod != longint'($signed(prod[31:0])));
   assign mult_ready    = !stub_never && (int'(stub_cnt) >= stub_k - 1);

   typedef struct {
      int          at_edge;
      logic [31:0] res;
      logic        exc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;
   int   req_edge = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, edge_cnt);
      end
   endtask

   // Scoreboard consumer: every strobe must match the oldest expectation.
   always @(negedge clock) begin
      if (data_resultRDY === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_rdy", 32'(data_resultRDY), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("rdy_edge", edge_cnt, mon_e.at_edge);
            check("result", data_result, mon_e.res);
            check("exception", 32'(data_exception), 32'(mon_e.exc));
         end
      end
   end

   // Called at a negedge; the request is sampled at the next edge (req_edge).
   // Returns at the negedge of cycle 1. lat is the cycle number of the strobe.
   task automatic req(input logic [31:0] a, input logic [31:0] b, input bit has_exp,
                      input int lat, input logic [31:0] res, input logic exc);
      ctl_MULT      = 1'b1;
      data_operandA = a;
      data_operandB = b;
      req_edge      = edge_cnt + 1;
      if (has_exp) sb.push_back('{req_edge + lat - 1, res, exc});
      @(negedge clock);
      ctl_MULT = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clock);
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      repeat (3) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clock);
      check("rst_result", data_result, 0);
      check("rst_exception", 32'(data_exception), 0);
      check("rst_rdy", 32'(data_resultRDY), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_mcand", mult_multiplicand, 0);
      check("rst_mplier", mult_multiplier, 0);
      check("rst_mult_reset", 32'(mult_reset), 1);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("post_rst_mult_reset", 32'(mult_reset), 0);
      check("post_rst_busy", 32'(busy), 0);

      // Basic multiply, K=16: strobe in cycle 18, busy in cycles 1..17
      stub_k = 16;
      req(32'd7, 32'hFFFF_FFFD, 1'b1, 18, 32'hFFFF_FFEB, 1'b0);
      check("basic_mcand", mult_multiplicand, 32'd7);
      check("basic_mplier", mult_multiplier, 32'hFFFF_FFFD);
      for (int c = 1; c <= 19; c++) begin
         check($sformatf("basic_busy_c%0d", c), 32'(busy), 32'(c <= 17));
         check($sformatf("basic_mreset_c%0d", c), 32'(mult_reset), 32'(c == 1));
         @(negedge clock);
      end
      check("basic_hold", data_result, 32'hFFFF_FFEB);
      drain(10);

      // Zero fast path, then a back-to-back zero request accepted in DONE
      req(32'd0, 32'h1234_5678, 1'b1, 1, 32'd0, 1'b0);
      check("zero_mreset", 32'(mult_reset), 0);
      check("zero_busy", 32'(busy), 0);
      check("zero_mplier", mult_multiplier, 32'h1234_5678);
      req(32'd5, 32'd0, 1'b1, 1, 32'd0, 1'b0);
      check("zero2_mreset", 32'(mult_reset), 0);
      check("zero2_mcand", mult_multiplicand, 32'd5);
      drain(10);

      // Overflow
      req(32'h0001_0000, 32'h0001_0000, 1'b1, 18, 32'd0, 1'b1);
      drain(40);

      // Restart: second request at edge 8 re-clears, single strobe in cycle 26
      req(32'd5, 32'd6, 1'b0, 0, 32'd0, 1'b0);
      repeat (7) @(negedge clock);
      req(32'd3, 32'd4, 1'b1, 18, 32'd12, 1'b0);
      check("restart_mreset_c9", 32'(mult_reset), 1);
      check("restart_mcand", mult_multiplicand, 32'd3);
      drain(40);

      // Watchdog timeout: strobe in cycle TIMEOUT+2
      stub_never = 1'b1;
      req(32'd11, 32'd13, 1'b1, TIMEOUT + 2, 32'd0, 1'b1);
      drain(40);
      stub_never = 1'b0;

      // Ready coincides with the timeout condition: ready wins
      stub_k = TIMEOUT;
      req(32'd1000, 32'd3, 1'b1, TIMEOUT + 2, 32'd3000, 1'b0);
      drain(40);
      stub_k = 16;

      // Reset mid-RUN at edge 10: everything cleared, multiplier cleared, no strobe
      req(32'd2, 32'd3, 1'b0, 0, 32'd0, 1'b0);
      repeat (9) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("midrst_result", data_result, 0);
      check("midrst_exception", 32'(data_exception), 0);
      check("midrst_rdy", 32'(data_resultRDY), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_mcand", mult_multiplicand, 0);
      check("midrst_mplier", mult_multiplier, 0);
      check("midrst_mreset_c11", 32'(mult_reset), 1);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("midrst_idle_busy", 32'(busy), 0);
      check("midrst_idle_mreset", 32'(mult_reset), 0);
      repeat (30) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
